// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NUM_REQ requesters; optional
// signed-overflow output when ADDER_RR_ARBITER_OVF_EN is defined.
// Latency: 1 cycle accept-to-rsp_valid. Backpressure: single-entry output stage; no req_ready while FULL && !rsp_ready.

module adder_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

module adder_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_in1,
    input  logic [NUM_REQ*32-1:0]   req_in2,
    input  logic [NUM_REQ-1:0]      req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_sum,
    output logic                    rsp_cout
`ifdef ADDER_RR_ARBITER_OVF_EN
    ,
    output logic                    rsp_ovf
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              can_accept;
    logic              found;
    logic [ID_W-1:0]   cand_idx;
    logic [ID_W-1:0]   grant_idx;
    logic              grant;

    logic [31:0]       sel_in1;
    logic [31:0]       sel_in2;
    logic              sel_cin;
    logic [31:0]       add_sum;
    logic              add_cout;

    assign can_accept = (state_q == EMPTY) || rsp_ready;

    // Rotating priority search: first valid requester at or above ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        cand_idx  = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant     = found && can_accept;
    assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    assign sel_in1 = req_in1[32*grant_idx +: 32];
    assign sel_in2 = req_in2[32*grant_idx +: 32];
    assign sel_cin = req_cin[grant_idx];

    adder_32 u_adder (
        .a_i    (sel_in1),
        .b_i    (sel_in2),
        .cin_i  (sel_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            EMPTY: begin
                if (grant) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !grant) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (grant) begin
            id_d   = grant_idx;
            sum_d  = add_sum;
            cout_d = add_cout;
            if (int'(grant_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

`ifdef ADDER_RR_ARBITER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (grant) begin
            ovf_d = (sel_in1[31] == sel_in2[31]) && (add_sum[31] != sel_in1[31]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a spec-level reference model.
module tb_adder_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_in1 = '0;
    logic [NUM_REQ*32-1:0] req_in2 = '0;
    logic [NUM_REQ-1:0]    req_cin = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  rsp_cout;
`ifdef ADDER_RR_ARBITER_OVF_EN
    logic                  rsp_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_RR_ARBITER_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
        req_cin[i]          = c;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[7];

    // Reference model state for the random phase
    int          m_ptr;
    bit          m_full;
    int          m_id;
    logic [32:0] m_res;
    logic        m_ovf;
    int          waits[NUM_REQ];

    initial begin
        vecs[0] = '{2, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0009, 1'b0, 1'b0};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{3, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{3, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

        // Reset state
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id",    64'(rsp_id),    64'd0);
        chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("reset_rsp_cout",  64'(rsp_cout),  64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
`ifdef ADDER_RR_ARBITER_OVF_EN
        chk("reset_rsp_ovf",   64'(rsp_ovf),   64'd0);
`endif
        #6;
        rst = 1'b0;

        // Directed single-op vectors
        for (int v = 0; v < 7; v++) begin
            req_valid = '0;
            set_ops(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].c);
            req_valid[vecs[v].r] = 1'b1;
            #1;
            chk("vec_req_ready", 64'(req_ready), 64'(4'b0001 << vecs[v].r));
            tick();
            req_valid = '0;
            chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("vec_rsp_id",    64'(rsp_id),    64'(vecs[v].r));
            chk("vec_rsp_sum",   64'(rsp_sum),   64'(vecs[v].s));
            chk("vec_rsp_cout",  64'(rsp_cout),  64'(vecs[v].co));
`ifdef ADDER_RR_ARBITER_OVF_EN
            chk("vec_rsp_ovf",   64'(rsp_ovf),   64'(vecs[v].ov));
`endif
        end

        // Round-robin with all requesters valid, pointer back at 0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_ops(i, 32'h100 * (i + 1), 32'(i), i[0]);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_req_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rr_rsp_id",    64'(rsp_id),    64'(k % 4));
            chk("rr_rsp_sum",   64'(rsp_sum),   64'(32'h100 * ((k % 4) + 1) + (k % 4) + ((k % 4) & 1)));
        end

        // Pointer skip: last grant was 1, only 0 and 3 valid
        req_valid = 4'b1001;
        #1;
        chk("skip_ready_3", 64'(req_ready), 64'b1000);
        tick();
        chk("skip_id_3", 64'(rsp_id), 64'd3);
        chk("skip_ready_0", 64'(req_ready), 64'b0001);
        tick();
        chk("skip_id_0", 64'(rsp_id), 64'd0);

        // Backpressure with result 0x10 held
        set_ops(0, 32'h10, 32'h0, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("bp_load_ready", 64'(req_ready), 64'b0001);
        tick();
        rsp_ready = 1'b0;
        set_ops(1, 32'h20, 32'h0, 1'b0);
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_sum",   64'(rsp_sum),   64'h10);
            chk("bp_rsp_id",    64'(rsp_id),    64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        chk("bp_next_valid", 64'(rsp_valid), 64'd1);
        chk("bp_next_sum",   64'(rsp_sum),   64'h20);
        chk("bp_next_id",    64'(rsp_id),    64'd1);
        tick();
        chk("bp_drain_empty", 64'(rsp_valid), 64'd0);

        // Async reset while a result is pending
        set_ops(3, 32'h55, 32'h1, 1'b0);
        req_valid = 4'b1000;
        #1;
        tick();
        req_valid = '0;
        chk("ar_pending", 64'(rsp_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid_drop", 64'(rsp_valid), 64'd0);
        chk("ar_sum_clear",  64'(rsp_sum),   64'd0);
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("ar_first_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        chk("ar_first_id", 64'(rsp_id), 64'd1);
        tick();

        // Randomized traffic against the reference model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_ptr  = 0;
        m_full = 1'b0;
        m_id   = 0;
        m_res  = '0;
        m_ovf  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
        begin
            int          last_g;
            int          g;
            logic [31:0] ga, gb;
            logic        gc;
            logic [NUM_REQ-1:0] vsnap;
            last_g = -1;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!req_valid[i] || last_g == i) begin
                        req_valid[i] = ($urandom_range(0, 99) < 60);
                        set_ops(i, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
                    end else if ($urandom_range(0, 99) < 5) begin
                        req_valid[i] = 1'b0;
                    end
                end
                rsp_ready = ($urandom_range(0, 99) < 70);
                #1;
                g = -1;
                if (!m_full || rsp_ready) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                    end
                end
                chk("rand_req_ready", 64'(req_ready), (g >= 0) ? 64'(4'b0001 << g) : 64'd0);
                vsnap = req_valid;
                ga = (g >= 0) ? req_in1[32*g +: 32] : 32'd0;
                gb = (g >= 0) ? req_in2[32*g +: 32] : 32'd0;
                gc = (g >= 0) ? req_cin[g] : 1'b0;
                tick();
                if (g >= 0) begin
                    m_full = 1'b1;
                    m_id   = g;
                    m_res  = {1'b0, ga} + {1'b0, gb} + 33'(gc);
                    m_ovf  = (ga[31] == gb[31]) && (m_res[31] != ga[31]);
                    m_ptr  = (g + 1) % NUM_REQ;
                end else if (rsp_ready) begin
                    m_full = 1'b0;
                end
                chk("rand_rsp_valid", 64'(rsp_valid), 64'(m_full));
                if (m_full) begin
                    chk("rand_rsp_id",   64'(rsp_id),   64'(m_id));
                    chk("rand_rsp_sum",  64'(rsp_sum),  64'(m_res[31:0]));
                    chk("rand_rsp_cout", 64'(rsp_cout), 64'(m_res[32]));
`ifdef ADDER_RR_ARBITER_OVF_EN
                    chk("rand_rsp_ovf",  64'(rsp_ovf),  64'(m_ovf));
`endif
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (g == i) begin
                        chk("rand_fair_wait", 64'(waits[i] <= NUM_REQ - 1), 64'd1);
                        waits[i] = 0;
                    end else if (!vsnap[i]) begin
                        waits[i] = 0;
                    end else if (g >= 0) begin
                        waits[i]++;
                    end
                end
                last_g = g;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
